// File: rtl/ofs_pcie_ss_tx_arb.sv
// ofs_pcie_ss_tx_arb
//   Packet-atomic, round-robin merge of two AXI-S TX requesters (A, B) onto a
//   single PCIe SS TX stream. The output is a zero-latency mux of the granted
//   source. A packet whose first beat carries the store-commit bit
//   (tuser[TUSER_WIDTH-1]) also produces one entry on the local commit stream
//   once its tlast beat has been accepted.
//   Build option OFS_PCIE_SS_TX_ARB_COMMIT_EN: when defined, the commit FIFO and
//   slot reservation are built. When undefined, the cmt_* outputs are tied low,
//   cmt_ready is ignored and the commit bit has no effect on arbitration.
//   TDATA_WIDTH must be >= 128. COMMIT_DEPTH must be a power of 2 and >= 2.
module ofs_pcie_ss_tx_arb #(
    parameter int TDATA_WIDTH  = 512,
    parameter int TUSER_WIDTH  = 10,
    parameter int COMMIT_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_tvalid,
    output logic                   a_tready,
    input  logic                   a_tlast,
    input  logic [TDATA_WIDTH-1:0] a_tdata,
    input  logic [TUSER_WIDTH-1:0] a_tuser,
    input  logic                   b_tvalid,
    output logic                   b_tready,
    input  logic                   b_tlast,
    input  logic [TDATA_WIDTH-1:0] b_tdata,
    input  logic [TUSER_WIDTH-1:0] b_tuser,
    output logic                   o_tvalid,
    input  logic                   o_tready,
    output logic                   o_tlast,
    output logic [TDATA_WIDTH-1:0] o_tdata,
    output logic [TUSER_WIDTH-1:0] o_tuser,
    output logic                   cmt_valid,
    input  logic                   cmt_ready,
    output logic                   cmt_chan,
    output logic [127:0]           cmt_hdr
);
    typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;
    localparam int CMT_BIT = TUSER_WIDTH - 1;

    state_t state_q, state_d;
    logic   prio_q, prio_d;          // source favoured on a tie: 0 = A, 1 = B
    logic   hold_q, hold_d;          // an IDLE offer stalled last cycle
    logic   hold_src_q, hold_src_d;  // ... and which source it came from

    logic [1:0] src_tvalid, src_cmt, elig;
    logic       slot_ok;
    logic       sel_src, sel_act, sel_vld;
    logic       sel_tlast;
    logic [TDATA_WIDTH-1:0] sel_tdata;
    logic [TUSER_WIDTH-1:0] sel_tuser;
    logic       accept, first_acc, last_acc;

    assign src_tvalid = {b_tvalid, a_tvalid};
    assign src_cmt    = {b_tuser[CMT_BIT], a_tuser[CMT_BIT]};

    // A source may win IDLE arbitration only if its commit (if requested) has a slot.
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
        assign elig[gi] = src_tvalid[gi] & (~src_cmt[gi] | slot_ok);
    end

    // Grant selection: locked source mid-packet, otherwise round-robin among eligible.
    always_comb begin
        sel_src = 1'b0;
        sel_act = 1'b0;
        case (state_q)
            LOCK_A: begin
                sel_src = 1'b0;
                sel_act = 1'b1;
            end
            LOCK_B: begin
                sel_src = 1'b1;
                sel_act = 1'b1;
            end
            default: begin
                sel_act = elig[0] | elig[1];
                // A stalled offer keeps its source so the beat stays stable.
                if (hold_q)
                    sel_src = hold_src_q;
                else if (elig[0] && elig[1])
                    sel_src = prio_q;
                else
                    sel_src = ~elig[0];
            end
        endcase
    end

    assign sel_vld   = sel_act & (sel_src ? b_tvalid : a_tvalid);
    assign sel_tlast = sel_src ? b_tlast : a_tlast;
    assign sel_tdata = sel_src ? b_tdata : a_tdata;
    assign sel_tuser = sel_src ? b_tuser : a_tuser;

    // Output and handshakes are forced low while reset is asserted.
    assign o_tvalid = rst_n & sel_vld;
    assign o_tlast  = rst_n & sel_vld & sel_tlast;
    assign o_tdata  = rst_n ? sel_tdata : '0;
    assign o_tuser  = rst_n ? sel_tuser : '0;
    assign a_tready = rst_n & o_tready & sel_act & ~sel_src;
    assign b_tready = rst_n & o_tready & sel_act & sel_src;

    assign accept    = o_tvalid & o_tready;
    assign first_acc = accept & (state_q == IDLE);
    assign last_acc  = accept & sel_tlast;

    // Next state: lock on a multi-beat first beat, release and rotate on tlast.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        hold_d     = 1'b0;
        hold_src_d = hold_src_q;
        if ((state_q == IDLE) && o_tvalid && !o_tready) begin
            hold_d     = 1'b1;
            hold_src_d = sel_src;
        end
        if (first_acc && !sel_tlast)
            state_d = sel_src ? LOCK_B : LOCK_A;
        if (last_acc) begin
            state_d = IDLE;
            prio_d  = ~sel_src;
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            hold_q     <= 1'b0;
            hold_src_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            hold_q     <= hold_d;
            hold_src_q <= hold_src_d;
        end
    end

`ifdef OFS_PCIE_SS_TX_ARB_COMMIT_EN
    localparam int PTR_W = $clog2(COMMIT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 129;  // {chan, hdr[127:0]}

    logic [ENT_W-1:0] mem_q [COMMIT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pend_q;      // a slot is reserved by the packet in flight
    logic [ENT_W-1:0] pend_ent_q;
    logic [ENT_W-1:0] first_ent, push_ent;
    logic             cmt_req, push, pop, fifo_vld;

    // Reserved slot counts against capacity so a commit can never be dropped.
    assign slot_ok   = (count_q + CNT_W'(pend_q)) < CNT_W'(COMMIT_DEPTH);
    assign cmt_req   = sel_tuser[CMT_BIT];
    assign first_ent = {sel_src, sel_tdata[127:0]};
    // Single-beat commit packets push straight from the bus; others from the latch.
    assign push      = (first_acc & cmt_req & sel_tlast) | (last_acc & pend_q);
    assign push_ent  = pend_q ? pend_ent_q : first_ent;
    assign fifo_vld  = (count_q != '0);
    assign pop       = fifo_vld & cmt_ready;

    assign cmt_valid = rst_n & fifo_vld;
    assign cmt_chan  = cmt_valid & mem_q[rd_ptr_q][ENT_W-1];
    assign cmt_hdr   = cmt_valid ? mem_q[rd_ptr_q][127:0] : '0;

    // FIFO pointers, occupancy and reservation flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (first_acc && cmt_req && !sel_tlast)
                pend_q <= 1'b1;
            else if (last_acc)
                pend_q <= 1'b0;
        end
    end

    // Commit storage and first-beat header latch; contents are qualified by the flags.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= push_ent;
        if (first_acc)
            pend_ent_q <= first_ent;
    end
`else
    logic unused_cmt_ready;

    assign slot_ok          = 1'b1;
    assign cmt_valid        = 1'b0;
    assign cmt_chan         = 1'b0;
    assign cmt_hdr          = '0;
    assign unused_cmt_ready = cmt_ready;
`endif

endmodule

// File: tb/tb_ofs_pcie_ss_tx_arb.sv
// Directed bench for ofs_pcie_ss_tx_arb. Runs the commit scenarios when built
// with OFS_PCIE_SS_TX_ARB_COMMIT_EN, the commit-disabled equivalents otherwise.
`timescale 1ns/1ps
module tb_ofs_pcie_ss_tx_arb;
    localparam int TDW   = 512;
    localparam int TUW   = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           s_tvalid [2];
    logic           s_tlast  [2];
    logic [TDW-1:0] s_tdata  [2];
    logic [TUW-1:0] s_tuser  [2];
    logic           a_tready, b_tready;
    logic           o_tvalid, o_tready, o_tlast;
    logic [TDW-1:0] o_tdata;
    logic [TUW-1:0] o_tuser;
    logic           cmt_valid, cmt_ready, cmt_chan;
    logic [127:0]   cmt_hdr;

    ofs_pcie_ss_tx_arb #(
        .TDATA_WIDTH (TDW),
        .TUSER_WIDTH (TUW),
        .COMMIT_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_tvalid (s_tvalid[0]),
        .a_tready (a_tready),
        .a_tlast  (s_tlast[0]),
        .a_tdata  (s_tdata[0]),
        .a_tuser  (s_tuser[0]),
        .b_tvalid (s_tvalid[1]),
        .b_tready (b_tready),
        .b_tlast  (s_tlast[1]),
        .b_tdata  (s_tdata[1]),
        .b_tuser  (s_tuser[1]),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .o_tlast  (o_tlast),
        .o_tdata  (o_tdata),
        .o_tuser  (o_tuser),
        .cmt_valid(cmt_valid),
        .cmt_ready(cmt_ready),
        .cmt_chan (cmt_chan),
        .cmt_hdr  (cmt_hdr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [TDW-1:0] got, input logic [TDW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Beat payload: id in [63:32], its complement at the top, header in [15:0].
    function automatic logic [TDW-1:0] mk_data(input int s, input int p, input int b, input logic [15:0] hdr);
        logic [TDW-1:0] d;
        d = '0;
        d[63:32]      = {8'(s), 8'(p), 8'(b), 8'h5A};
        d[TDW-1 -: 32] = ~d[63:32];
        d[15:0]       = hdr;
        return d;
    endfunction

    // Commit bit carried on every beat of a commit packet; only the first should matter.
    function automatic logic [TUW-1:0] mk_user(input int s, input int b, input bit cmt);
        logic [TUW-1:0] u;
        u = TUW'(s * 16 + b);
        u[TUW-1] = cmt;
        return u;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [TDW-1:0] exp_d[$], got_d[$];
    logic [TUW:0]   exp_u[$], got_u[$];
    int  cyc = 0;
    int  first_cyc, last_cyc, cmt_seen, stable_err;
    int  tmo [2];
    bit  mon_en = 0;
    bit  tog_en = 0;
    bit  stall_q = 0;
    logic [TDW-1:0] stall_d;
    logic [TUW:0]   stall_u;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (stall_q && (!o_tvalid || o_tdata !== stall_d || {o_tlast, o_tuser} !== stall_u))
                stable_err++;
            if (o_tvalid && o_tready) begin
                got_d.push_back(o_tdata);
                got_u.push_back({o_tlast, o_tuser});
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                $display("txn cyc=%0d id=%h last=%b tuser=%h", cyc, o_tdata[63:32], o_tlast, o_tuser);
            end
            if (cmt_valid) cmt_seen++;
            stall_q = o_tvalid && !o_tready;
            stall_d = o_tdata;
            stall_u = {o_tlast, o_tuser};
        end else begin
            stall_q = 0;
        end
    end

    // o_tready toggler for stall scenarios.
    initial forever begin
        @(posedge clk);
        #1;
        if (tog_en) o_tready = ~o_tready;
    end

    task automatic expect_pkt(input int s, input int p, input int len, input bit cmt, input logic [15:0] hbase);
        for (int b = 0; b < len; b++) begin
            exp_d.push_back(mk_data(s, p, b, hbase + 16'(p)));
            exp_u.push_back({(b == len - 1), mk_user(s, b, cmt)});
        end
    endtask

    task automatic cmp_seq(input string tag);
        check({tag, "_len"}, TDW'(got_d.size()), TDW'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            check($sformatf("%s_user%0d", tag, i), TDW'(got_u[i]), TDW'(exp_u[i]));
        end
    endtask

    // Source driver: presents npkt packets of len beats, bounded wait per beat.
    task automatic send(input int s, input int npkt, input int len, input bit cmt, input logic [15:0] hbase);
        bit done;
        int waited;
        for (int p = 0; p < npkt; p++) begin
            for (int b = 0; b < len; b++) begin
                s_tvalid[s] = 1'b1;
                s_tlast[s]  = (b == len - 1);
                s_tdata[s]  = mk_data(s, p, b, hbase + 16'(p));
                s_tuser[s]  = mk_user(s, b, cmt);
                done   = 0;
                waited = 0;
                while (!done) begin
                    @(negedge clk);
                    done = (s == 0) ? a_tready : b_tready;
                    @(posedge clk);
                    #1;
                    if (!done) begin
                        waited++;
                        if (waited >= 40) begin
                            tmo[s]++;
                            s_tvalid[s] = 1'b0;
                            s_tlast[s]  = 1'b0;
                            return;
                        end
                    end
                end
            end
        end
        s_tvalid[s] = 1'b0;
        s_tlast[s]  = 1'b0;
    endtask

    task automatic idle_srcs();
        for (int s = 0; s < 2; s++) begin
            s_tvalid[s] = 1'b0;
            s_tlast[s]  = 1'b0;
            s_tdata[s]  = '0;
            s_tuser[s]  = '0;
        end
    endtask

    task automatic start_scn();
        mon_en = 0;
        rst_n  = 1'b0;
        idle_srcs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_d.delete(); exp_u.delete(); got_d.delete(); got_u.delete();
        first_cyc  = -1;
        last_cyc   = -1;
        cmt_seen   = 0;
        stable_err = 0;
        tmo[0]     = 0;
        tmo[1]     = 0;
        mon_en     = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [TDW-1:0] ed;

    initial begin
        rst_n     = 1'b0;
        o_tready  = 1'b0;
        cmt_ready = 1'b0;
        idle_srcs();

        // ---- reset state with live inputs ----
        s_tvalid[0] = 1'b1; s_tdata[0] = mk_data(0, 9, 0, 16'hAAAA); s_tlast[0] = 1'b1;
        s_tvalid[1] = 1'b1; s_tdata[1] = mk_data(1, 9, 0, 16'hBBBB); s_tlast[1] = 1'b1;
        o_tready  = 1'b1;
        cmt_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_o_tvalid", TDW'(o_tvalid), TDW'(0));
        check("rst_a_tready", TDW'(a_tready), TDW'(0));
        check("rst_b_tready", TDW'(b_tready), TDW'(0));
        check("rst_cmt_valid", TDW'(cmt_valid), TDW'(0));
        check("rst_o_tdata", o_tdata, '0);
        cmt_ready = 1'b0;

        // ---- continuous 3-beat packets from both: A,B alternate, no bubbles ----
        start_scn();
        o_tready = 1'b1;
        fork
            send(0, 3, 3, 1'b0, 16'h0100);
            send(1, 3, 3, 1'b0, 16'h0200);
        join
        for (int p = 0; p < 3; p++) begin
            expect_pkt(0, p, 3, 1'b0, 16'h0100);
            expect_pkt(1, p, 3, 1'b0, 16'h0200);
        end
        cmp_seq("rr3");
        check("rr3_span", TDW'(last_cyc - first_cyc), TDW'(17));
        check("rr3_tmo", TDW'(tmo[0] + tmo[1]), TDW'(0));

        // ---- A 1-beat, B 4-beat with o_tready toggling ----
        start_scn();
        o_tready = 1'b0;
        tog_en   = 1;
        fork
            send(0, 1, 1, 1'b0, 16'h0300);
            send(1, 1, 4, 1'b0, 16'h0400);
        join
        tog_en = 0;
        @(posedge clk);
        #1;
        o_tready = 1'b1;
        expect_pkt(0, 0, 1, 1'b0, 16'h0300);
        expect_pkt(1, 0, 4, 1'b0, 16'h0400);
        cmp_seq("stall");
        check("stall_stable", TDW'(stable_err), TDW'(0));

        // ---- B alone: sole eligible source wins back-to-back ----
        start_scn();
        fork
            send(1, 2, 2, 1'b0, 16'h0500);
        join
        expect_pkt(1, 0, 2, 1'b0, 16'h0500);
        expect_pkt(1, 1, 2, 1'b0, 16'h0500);
        cmp_seq("solo");

        // ---- reset on beat 2 of a 4-beat commit packet from A ----
        start_scn();
        cmt_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            s_tvalid[0] = 1'b1;
            s_tlast[0]  = 1'b0;
            s_tdata[0]  = mk_data(0, 0, b, 16'h0600);
            s_tuser[0]  = mk_user(0, b, 1'b1);
            if (b < 2) begin
                @(posedge clk);
                #1;
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_o_tvalid", TDW'(o_tvalid), TDW'(0));
        check("mid_rst_a_tready", TDW'(a_tready), TDW'(0));
        check("mid_rst_o_tdata", o_tdata, '0);
        @(posedge clk);
        #1;
        idle_srcs();
        @(negedge clk);
        check("mid_rst_next_o_tvalid", TDW'(o_tvalid), TDW'(0));
        check("mid_rst_next_cmt_valid", TDW'(cmt_valid), TDW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s_tvalid[1] = 1'b1;
        s_tlast[1]  = 1'b1;
        s_tdata[1]  = mk_data(1, 0, 0, 16'h0700);
        s_tuser[1]  = mk_user(1, 0, 1'b0);
        @(negedge clk);
        check("post_rst_grant_b", TDW'(b_tready), TDW'(1));
        @(posedge clk);
        #1;
        idle_srcs();
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("post_rst_no_cmt", TDW'(cmt_seen), TDW'(0));
        for (int b = 0; b < 2; b++) begin
            exp_d.push_back(mk_data(0, 0, b, 16'h0600));
            exp_u.push_back({1'b0, mk_user(0, b, 1'b1)});
        end
        expect_pkt(1, 0, 1, 1'b0, 16'h0700);
        cmp_seq("midrst");

        // ---- A sends 5 commit packets with cmt_ready=0, B non-commit traffic ----
        start_scn();
        o_tready  = 1'b1;
        cmt_ready = 1'b0;
        fork
            send(0, 5, 2, 1'b1, 16'h1000);
            send(1, 3, 2, 1'b0, 16'h2000);
        join
        for (int p = 0; p < 3; p++) begin
            expect_pkt(0, p, 2, 1'b1, 16'h1000);
            expect_pkt(1, p, 2, 1'b0, 16'h2000);
        end
        expect_pkt(0, 3, 2, 1'b1, 16'h1000);
`ifdef OFS_PCIE_SS_TX_ARB_COMMIT_EN
        cmp_seq("cmtfull");
        check("cmtfull_a_tmo", TDW'(tmo[0]), TDW'(1));
        check("cmtfull_b_tmo", TDW'(tmo[1]), TDW'(0));
        s_tvalid[0] = 1'b1;
        s_tlast[0]  = 1'b0;
        s_tdata[0]  = mk_data(0, 4, 0, 16'h1004);
        s_tuser[0]  = mk_user(0, 0, 1'b1);
        @(negedge clk);
        check("cmtfull_a_blocked", TDW'(a_tready), TDW'(0));
        @(posedge clk);
        #1;
        idle_srcs();
        cmt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ed = mk_data(0, i, 0, 16'h1000 + 16'(i));
            check($sformatf("pop%0d_valid", i), TDW'(cmt_valid), TDW'(1));
            check($sformatf("pop%0d_chan", i), TDW'(cmt_chan), TDW'(0));
            check($sformatf("pop%0d_hdr", i), TDW'(cmt_hdr), TDW'(ed[127:0]));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("pop_empty", TDW'(cmt_valid), TDW'(0));
        cmt_ready = 1'b0;

        // ---- B 2-beat commit packet, header 0x1234 ----
        start_scn();
        s_tvalid[1] = 1'b1;
        s_tlast[1]  = 1'b0;
        s_tdata[1]  = mk_data(1, 0, 0, 16'h1234);
        s_tuser[1]  = mk_user(1, 0, 1'b1);
        @(negedge clk);
        check("c31_b_tready", TDW'(b_tready), TDW'(1));
        @(posedge clk);
        #1;
        s_tlast[1] = 1'b1;
        s_tdata[1] = mk_data(1, 0, 1, 16'h0000);
        s_tuser[1] = mk_user(1, 1, 1'b0);
        @(negedge clk);
        check("c31_before_last", TDW'(cmt_valid), TDW'(0));
        @(posedge clk);
        #1;
        idle_srcs();
        @(negedge clk);
        ed = mk_data(1, 0, 0, 16'h1234);
        check("c31_cmt_valid", TDW'(cmt_valid), TDW'(1));
        check("c31_cmt_chan", TDW'(cmt_chan), TDW'(1));
        check("c31_cmt_hdr16", TDW'(cmt_hdr[15:0]), TDW'(16'h1234));
        check("c31_cmt_hdr", TDW'(cmt_hdr), TDW'(ed[127:0]));
`else
        expect_pkt(0, 4, 2, 1'b1, 16'h1000);
        cmp_seq("nocmt");
        check("nocmt_tmo", TDW'(tmo[0] + tmo[1]), TDW'(0));
        check("nocmt_cmt_seen", TDW'(cmt_seen), TDW'(0));
        cmt_ready = 1'b1;
        @(negedge clk);
        check("nocmt_cmt_valid", TDW'(cmt_valid), TDW'(0));
        cmt_ready = 1'b0;
`endif

        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ofs_pcie_ss_tx_arb.md
OFS_PCIE_SS_TX_ARB -- requirements
Module: ofs_pcie_ss_tx_arb

Interface
REQ-001 Param TDATA_WIDTH, default 512, tdata width of every stream; SHALL be >= 128.
REQ-002 Param TUSER_WIDTH, default 10, tuser width of every stream; bit TUSER_WIDTH-1 is the store-commit request bit.
REQ-003 Param COMMIT_DEPTH, default 4, commit FIFO entries; SHALL be a power of 2, >= 2.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 a_tvalid/a_tready/a_tlast  in/out/in  1 each  requester A AXI-S handshake and end of packet.
REQ-007 a_tdata  in  TDATA_WIDTH; a_tuser  in  TUSER_WIDTH  requester A payload and flags.
REQ-008 b_tvalid/b_tready/b_tlast, b_tdata, b_tuser  same widths  requester B.
REQ-009 o_tvalid/o_tready/o_tlast  out/in/out  1 each; o_tdata  out  TDATA_WIDTH; o_tuser  out  TUSER_WIDTH  merged stream to PCIe SS TX.
REQ-010 cmt_valid  out  1; cmt_ready  in  1; cmt_chan  out  1 (0=A, 1=B); cmt_hdr  out  128  local write-commit stream.

Function
REQ-011 Arbitration SHALL be packet-atomic: once a packet's first beat is accepted on o_*, only that source is forwarded until its tlast beat is accepted.
REQ-012 States: IDLE, LOCK_A, LOCK_B; IDLE->LOCK_x on acceptance of a non-tlast first beat from x; LOCK_x->IDLE on acceptance of x's tlast beat; single-beat packets leave state in IDLE.
REQ-013 In IDLE, pick is round-robin: the source not granted last wins when both are eligible; the sole eligible source wins otherwise; priority register SHALL flip to the other source each time a packet's tlast is accepted.
REQ-014 o_* SHALL be a zero-latency combinational mux of the selected source; x_tready = o_tready AND x selected; unselected source tready = 0.
REQ-015 o_tvalid SHALL never depend on o_tready; data/tuser/tlast SHALL be held stable while o_tvalid and not o_tready.
REQ-016 A source is eligible in IDLE if tvalid=1 and, when its tuser commit bit is set, the commit FIFO has a free slot, counting slots reserved by in-flight packets.
REQ-017 On acceptance of a first beat with the commit bit set, the block SHALL latch {source, tdata[127:0]} and reserve one FIFO slot.
REQ-018 On acceptance of that packet's tlast beat, the latched entry SHALL be written to the commit FIFO (same edge); cmt_valid rises next cycle at earliest.
REQ-019 Commit FIFO SHALL be FIFO-ordered; cmt_valid = not empty; pop on cmt_valid AND cmt_ready; simultaneous push and pop when full-minus-reserve SHALL not lose or duplicate entries.
REQ-020 Occupancy plus reservations SHALL never exceed COMMIT_DEPTH; a commit-requesting source with no slot SHALL wait in IDLE while the other source may proceed.
REQ-021 Pointers SHALL wrap modulo COMMIT_DEPTH; count width is clog2(COMMIT_DEPTH)+1.
REQ-022 Commit bit on non-first beats SHALL be ignored; o_tuser forwards source tuser unchanged.

Reset
REQ-023 While rst_n=0 at a clock edge: state=IDLE, priority=A, FIFO empty, reservation cleared, o_tvalid=0, a_tready=0, b_tready=0, cmt_valid=0.
REQ-024 Reset mid-packet SHALL abandon the packet and discard its pending commit; no partial commit SHALL be emitted after reset.
REQ-025 First grant SHALL be possible on the first edge after rst_n returns to 1.

Configuration
REQ-026 Macro OFS_PCIE_SS_TX_ARB_COMMIT_EN: when defined, REQ-016..REQ-021 apply.
REQ-027 When undefined: no FIFO or reservation logic; cmt_valid tied 0, cmt_chan/cmt_hdr tied 0, cmt_ready ignored, commit bit ignored for eligibility; arbitration unchanged.

Verification
REQ-028 A and B each send continuous 3-beat packets, o_tready=1 -> output alternates A,B,A,B with no interleaved beats; 6 beats per pair.
REQ-029 A 1-beat packet, B 4-beat packet, o_tready toggling 1/0 -> outputs stable during stalls, order A then B, B beats contiguous.
REQ-030 COMMIT_DEPTH=4, cmt_ready=0, A sends 5 commit-bit packets -> 4 accepted, 5th stalls with a_tready=0; B non-commit packets continue flowing.
REQ-031 Commit packet with header 0x...1234 from B, 2 beats -> cmt_valid rises the cycle after tlast accepted, cmt_chan=1, cmt_hdr[15:0]=0x1234.
REQ-032 rst_n=0 asserted on beat 2 of a 4-beat commit packet -> all outputs 0 next cycle, FIFO empty, no commit emitted after release.
REQ-033 Build without OFS_PCIE_SS_TX_ARB_COMMIT_EN, repeat REQ-030 stimulus -> all 5 packets pass, cmt_valid stays 0.
